hssi_mbox_cmd_engine: RTL and testbench
=======================================

Name: hssi_mbox_cmd_engine

Overview:
- Multi-channel successor to the single HSSI traffic-controller mailbox.
- Host software writes ADDRESS, WRDATA and CMD words. The engine decodes a channel index from ADDRESS and issues a single read or write on that channel's traffic-controller CSR port, or a broadcast write to every channel.
- It waits for acknowledge under a timeout and returns RDDATA plus sticky status.
- Sits between the HE-HSSI AFU CSR decoder, at mailbox base, and NUM_CH traffic-controller instances.

Parameters:
- NUM_CH, 16: number of traffic-controller channels, 1..16.
- DATA_W, 32: TC data width, also the mailbox word width.
- TC_ADDR_W, 16: TC register address width; ADDRESS[TC_ADDR_W-1:0].
- TIMEOUT, 1024: maximum cycles waited for acknowledge, ≥2.

Ports:
- clk, input, 1: sole clock.
- rst, input, 1: synchronous, active-high reset.
- csr_wr, input, 1: host write strobe.
- csr_rd, input, 1: host read strobe.
- csr_addr, input, 2: word select: 0=CMD, 1=ADDRESS, 2=RDDATA, 3=WRDATA (byte offsets 0x0/0x4/0x8/0xC).
- csr_wdata, input, DATA_W: host write data.
- csr_rdata, output, DATA_W: host read data.
- csr_rvalid, output, 1: read data valid.
- tc_req, output, NUM_CH: one-hot (or all-ones on broadcast) request pulse.
- tc_wr, output, 1: qualifies tc_req as a write.
- tc_addr, output, TC_ADDR_W: TC register address.
- tc_wdata, output, DATA_W: TC write data.
- tc_ack, input, NUM_CH: per-channel acknowledge pulse.
- tc_rdata, input, NUM_CH*DATA_W: per-channel read data, channel i at [i*DATA_W +: DATA_W].

Behaviour:
- Reset state: all registers 0, FSM IDLE, csr_rdata=0, csr_rvalid=0, tc_req=0, tc_wr=0, tc_addr=0, tc_wdata=0.
- ADDRESS layout:
  - [TC_ADDR_W-1:0]: register address.
  - [TC_ADDR_W+3:TC_ADDR_W]: channel.
  - [31]: broadcast.
- ADDRESS and WRDATA are writable at any time. They are snapshotted at command issue, so writes during busy affect only the next command.
- CMD write, bits[1:0]: 0=NOOP (no effect), 1=RD, 2=WR, 3=illegal.
- CMD read returns:
  - [1:0] last command
  - [2] busy
  - [3] done
  - [4] timeout
  - [5] err
  - [6] overrun
  - remaining bits 0.
- A CMD write with 1/2 in IDLE clears done, timeout and err, then:
  - The command is illegal if it is 3, if channel ≥ NUM_CH (non-broadcast), or if it is a broadcast RD.
  - Illegal: err=1, done=1, no TC access, stay IDLE.
  - Otherwise go to ISSUE and set busy=1.
- A CMD write with 1/2/3 while busy: ignored, overrun=1 (sticky, cleared only by reset or by writing CMD with bit[6]=1 while IDLE).
- FSM:
  - IDLE→ISSUE on a legal command.
  - ISSUE (1 cycle): tc_req pulses for exactly one cycle (one-hot of channel, or all NUM_CH bits on broadcast); tc_wr=(cmd==WR); tc_addr and tc_wdata driven from the snapshot and held until return to IDLE. Then go to WAIT, with pending mask = tc_req and counter=0.
  - WAIT: each cycle, clear pending bits where tc_ack is set. On RD ack, latch tc_rdata of the selected channel into RDDATA. Exit when pending==0: done=1, busy=0, go to IDLE.
  - WAIT timeout: counter increments every WAIT cycle. When counter==TIMEOUT-1 and pending is still non-zero after this cycle's acks: timeout=1, done=1, busy=0, RDDATA=all-ones for RD, go to IDLE.
- Ack precedence: an ack arriving on the terminal-count cycle that empties pending completes normally, with no timeout.
- Ignored acks: acks outside WAIT and acks on channels not pending. A duplicate ack has no effect.
- Host reads: csr_rvalid asserted exactly 1 cycle after csr_rd, with csr_rdata = the selected word as of the csr_rd cycle. A RDDATA read returns the last latched value.
- Simultaneous csr_wr and csr_rd in one cycle: both serviced; the read returns the pre-write value.
- Reset mid-operation: FSM→IDLE next cycle, all status 0, late tc_ack ignored.

Decomposition:
- Package hssi_mbox_pkg holds:
  - mailbox offsets: MB_CMD_OFFSET=0x0, MB_ADDRESS_OFFSET=0x4, MB_RDDATA_OFFSET=0x8, MB_WRDATA_OFFSET=0xC;
  - command enum: MB_NOOP=0, MB_RD=1, MB_WR=2;
  - packed mb_status_t with fields overrun, err, timeout, done, busy, cmd[1:0];
  - FSM state enum: IDLE, ISSUE, WAIT;
  - MB_BCAST_BIT=31.
- Single module. The timeout counter and pending-mask logic stay inline; no sub-module is warranted.

Test Plan:
- Read, channel 3: ADDRESS=0x0003_0009, CMD=1; ch3 acks 5 cycles after tc_req with 0x1234 → tc_req=0x0008 for one cycle; RDDATA=0x1234; CMD read = done=1, busy=0, cmd=1.
- Broadcast write: ADDRESS=0x8000_0200, WRDATA=1, CMD=2, NUM_CH=16; acks staggered over channels 0..15 → tc_req=0xFFFF for one cycle; done asserted only the cycle after the last ack; no timeout.
- Timeout: CMD=1 to channel 5, no ack → timeout=1, done=1, RDDATA=0xFFFF_FFFF exactly TIMEOUT cycles after WAIT entry. With an ack at cycle TIMEOUT-1 → normal completion, timeout=0.
- Illegal commands, each giving err=1, done=1, tc_req never asserted:
  - NUM_CH=4, channel 7;
  - CMD=3;
  - broadcast RD.
- Overrun: second CMD write while busy → overrun=1, first transaction completes unaffected. A later CMD write with bit[6]=1 while IDLE clears overrun.
- Reset: rst asserted during WAIT, then a late tc_ack → all status 0, RDDATA unchanged at 0, FSM IDLE.

Source files
------------

// File: rtl/hssi_mbox_pkg.sv
// Shared definitions for the multi-channel HSSI mailbox command engine.
// Contents:
//   - Mailbox byte offsets, and the 2-bit word select each one maps to.
//   - The host command encoding.
//   - The packed status word returned on a CMD read.
//   - The engine FSM state encoding.
//   - The position of the broadcast flag in ADDRESS.
package hssi_mbox_pkg;

  localparam logic [3:0] MB_CMD_OFFSET     = 4'h0;
  localparam logic [3:0] MB_ADDRESS_OFFSET = 4'h4;
  localparam logic [3:0] MB_RDDATA_OFFSET  = 4'h8;
  localparam logic [3:0] MB_WRDATA_OFFSET  = 4'hC;

  localparam int MB_BCAST_BIT = 31;

  typedef enum logic [1:0] {
    MB_NOOP = 2'd0,
    MB_RD   = 2'd1,
    MB_WR   = 2'd2
  } mb_cmd_e;

  // Bit order matches the CMD read layout:
  // [6] overrun, [5] err, [4] timeout, [3] done, [2] busy, [1:0] cmd.
  typedef struct packed {
    logic       overrun;
    logic       err;
    logic       timeout;
    logic       done;
    logic       busy;
    logic [1:0] cmd;
  } mb_status_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } mb_state_e;

  // The host bus carries a word index, so a byte offset maps to that index
  // by dropping its low two bits.
  function automatic logic [1:0] mb_word_sel(input logic [3:0] offset);
    return offset[3:2];
  endfunction

endpackage

// File: rtl/hssi_mbox_cmd_engine.sv
// Multi-channel HSSI mailbox command engine.
//
// Host software writes the ADDRESS, WRDATA and CMD words. A legal command
// issues one request to a traffic-controller channel, or a broadcast write
// to every channel. The engine then waits for the acknowledges under a
// timeout. It returns read data in RDDATA and keeps sticky status in CMD.
//
// Ports:
//   clk, rst    : clock; synchronous active-high reset.
//   csr_wr/rd   : host write and read strobes.
//   csr_addr    : word select (0=CMD, 1=ADDRESS, 2=RDDATA, 3=WRDATA).
//   csr_wdata   : host write data.
//   csr_rdata   : host read data, with csr_rvalid, one cycle after csr_rd.
//   tc_req      : per-channel request pulse (one-hot, or all ones on broadcast).
//   tc_wr       : marks the request as a write.
//   tc_addr     : TC register address.
//   tc_wdata    : TC write data.
//   tc_ack      : per-channel acknowledge pulses.
//   tc_rdata    : per-channel read data, channel i at [i*DATA_W +: DATA_W].
//
// Handshake: a request is a single-cycle tc_req pulse. It is complete when
// every requested channel has pulsed tc_ack while the engine is in WAIT.
// An ack seen in any other state, or on a channel that is not pending, is
// dropped.
module hssi_mbox_cmd_engine
  import hssi_mbox_pkg::*;
#(
  parameter int NUM_CH    = 16,
  parameter int DATA_W    = 32,
  parameter int TC_ADDR_W = 16,
  parameter int TIMEOUT   = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     csr_wr,
  input  logic                     csr_rd,
  input  logic [1:0]               csr_addr,
  input  logic [DATA_W-1:0]        csr_wdata,
  output logic [DATA_W-1:0]        csr_rdata,
  output logic                     csr_rvalid,
  output logic [NUM_CH-1:0]        tc_req,
  output logic                     tc_wr,
  output logic [TC_ADDR_W-1:0]     tc_addr,
  output logic [DATA_W-1:0]        tc_wdata,
  input  logic [NUM_CH-1:0]        tc_ack,
  input  logic [NUM_CH*DATA_W-1:0] tc_rdata
);

  localparam logic [1:0] SEL_CMD     = mb_word_sel(MB_CMD_OFFSET);
  localparam logic [1:0] SEL_ADDRESS = mb_word_sel(MB_ADDRESS_OFFSET);
  localparam logic [1:0] SEL_RDDATA  = mb_word_sel(MB_RDDATA_OFFSET);
  localparam logic [1:0] SEL_WRDATA  = mb_word_sel(MB_WRDATA_OFFSET);

  localparam int             CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [4:0]     NUM_CH_L = 5'(NUM_CH);

  mb_state_e          state;
  mb_status_t         status_q;
  logic [DATA_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wrdata_q;
  logic [DATA_W-1:0]  rddata_q;
  logic [NUM_CH-1:0]  pending;
  logic [CNT_W-1:0]   cnt;
  logic [3:0]         snap_ch;
  logic               snap_rd;

  logic               cmd_wr;
  logic [1:0]         cmd_in;
  logic [3:0]         ch_in;
  logic               bcast_in;
  logic               illegal;
  logic [NUM_CH-1:0]  req_mask;
  logic [NUM_CH-1:0]  pend_next;
  logic [DATA_W-1:0]  sel_rdata;
  logic [DATA_W-1:0]  rd_word;

  always_comb begin
    cmd_wr    = csr_wr && (csr_addr == SEL_CMD);
    cmd_in    = csr_wdata[1:0];
    ch_in     = addr_q[TC_ADDR_W+3:TC_ADDR_W];
    bcast_in  = addr_q[MB_BCAST_BIT];
    // Command value 3 is undefined. A broadcast read has no single source
    // for its data. A channel index past NUM_CH-1 has no TC behind it.
    illegal   = (cmd_in == 2'd3)
             || (!bcast_in && ({1'b0, ch_in} >= NUM_CH_L))
             || (bcast_in && (cmd_in == MB_RD));
    req_mask  = bcast_in ? {NUM_CH{1'b1}} : (NUM_CH'(1) << ch_in);
    pend_next = pending & ~tc_ack;
    sel_rdata = tc_rdata[int'(snap_ch)*DATA_W +: DATA_W];
  end

  always_comb begin
    rd_word = '0;
    case (csr_addr)
      SEL_CMD:     rd_word = DATA_W'(status_q);
      SEL_ADDRESS: rd_word = addr_q;
      SEL_RDDATA:  rd_word = rddata_q;
      SEL_WRDATA:  rd_word = wrdata_q;
      default:     rd_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      status_q   <= '0;
      addr_q     <= '0;
      wrdata_q   <= '0;
      rddata_q   <= '0;
      pending    <= '0;
      cnt        <= '0;
      snap_ch    <= '0;
      snap_rd    <= 1'b0;
      csr_rdata  <= '0;
      csr_rvalid <= 1'b0;
      tc_req     <= '0;
      tc_wr      <= 1'b0;
      tc_addr    <= '0;
      tc_wdata   <= '0;
    end else begin
      // The read sees register values from before any write in the same
      // cycle.
      csr_rvalid <= csr_rd;
      if (csr_rd) csr_rdata <= rd_word;

      // ADDRESS and WRDATA stay writable while busy. The TC side uses the
      // copies taken at issue, so these writes only affect the next command.
      if (csr_wr && (csr_addr == SEL_ADDRESS)) addr_q   <= csr_wdata;
      if (csr_wr && (csr_addr == SEL_WRDATA))  wrdata_q <= csr_wdata;

      tc_req <= '0;

      if ((state != IDLE) && cmd_wr && (cmd_in != MB_NOOP))
        status_q.overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (cmd_wr) begin
            if (csr_wdata[6]) status_q.overrun <= 1'b0;
            if (cmd_in != MB_NOOP) begin
              status_q.cmd     <= cmd_in;
              status_q.done    <= 1'b0;
              status_q.timeout <= 1'b0;
              status_q.err     <= 1'b0;
              if (illegal) begin
                status_q.err  <= 1'b1;
                status_q.done <= 1'b1;
              end else begin
                state         <= ISSUE;
                status_q.busy <= 1'b1;
                tc_req        <= req_mask;
                tc_wr         <= (cmd_in == MB_WR);
                tc_addr       <= addr_q[TC_ADDR_W-1:0];
                tc_wdata      <= wrdata_q;
                snap_ch       <= ch_in;
                snap_rd       <= (cmd_in == MB_RD);
              end
            end
          end
        end

        ISSUE: begin
          pending <= tc_req;
          cnt     <= '0;
          state   <= WAIT;
        end

        WAIT: begin
          pending <= pend_next;
          if (snap_rd && tc_ack[snap_ch] && pending[snap_ch])
            rddata_q <= sel_rdata;
          // An ack that empties the pending mask wins over the terminal count.
          if (pend_next == '0) begin
            status_q.done <= 1'b1;
            status_q.busy <= 1'b0;
            state         <= IDLE;
          end else if (cnt == CNT_LAST) begin
            status_q.timeout <= 1'b1;
            status_q.done    <= 1'b1;
            status_q.busy    <= 1'b0;
            if (snap_rd) rddata_q <= '1;
            state            <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hssi_mbox_cmd_engine.sv
// Directed bench for hssi_mbox_cmd_engine.
// Instance a uses NUM_CH=16, the full-width configuration.
// Instance b uses NUM_CH=4, to exercise the channel-range boundary.
// Both instances use TIMEOUT=16.
module tb_hssi_mbox_cmd_engine;

  localparam int TMO = 16;
  localparam logic [1:0] W_CMD = 2'd0, W_ADDR = 2'd1, W_RDD = 2'd2, W_WRD = 2'd3;

  int checks = 0;
  int errors = 0;

  logic         clk = 1'b0;
  logic         rst;

  // Instance a: 16 channels.
  logic         csr_wr, csr_rd;
  logic [1:0]   csr_addr;
  logic [31:0]  csr_wdata, csr_rdata;
  logic         csr_rvalid;
  logic [15:0]  tc_req, tc_ack;
  logic         tc_wr;
  logic [15:0]  tc_addr;
  logic [31:0]  tc_wdata;
  logic [511:0] tc_rdata;

  // Instance b: 4 channels.
  logic         b_csr_wr, b_csr_rd;
  logic [1:0]   b_csr_addr;
  logic [31:0]  b_csr_wdata, b_csr_rdata;
  logic         b_csr_rvalid;
  logic [3:0]   b_tc_req, b_tc_ack;
  logic         b_tc_wr;
  logic [15:0]  b_tc_addr;
  logic [31:0]  b_tc_wdata;
  logic [127:0] b_tc_rdata;

  hssi_mbox_cmd_engine #(.NUM_CH(16), .DATA_W(32), .TC_ADDR_W(16), .TIMEOUT(TMO)) dut_a (
    .clk(clk), .rst(rst), .csr_wr(csr_wr), .csr_rd(csr_rd), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_rvalid(csr_rvalid),
    .tc_req(tc_req), .tc_wr(tc_wr), .tc_addr(tc_addr), .tc_wdata(tc_wdata),
    .tc_ack(tc_ack), .tc_rdata(tc_rdata)
  );

  hssi_mbox_cmd_engine #(.NUM_CH(4), .DATA_W(32), .TC_ADDR_W(16), .TIMEOUT(TMO)) dut_b (
    .clk(clk), .rst(rst), .csr_wr(b_csr_wr), .csr_rd(b_csr_rd), .csr_addr(b_csr_addr),
    .csr_wdata(b_csr_wdata), .csr_rdata(b_csr_rdata), .csr_rvalid(b_csr_rvalid),
    .tc_req(b_tc_req), .tc_wr(b_tc_wr), .tc_addr(b_tc_addr), .tc_wdata(b_tc_wdata),
    .tc_ack(b_tc_ack), .tc_rdata(b_tc_rdata)
  );

  // Clock and reset.
  always #5 clk = ~clk;

  // Driver tasks for instance a. Inputs change 1 time unit after a rising
  // edge, and outputs are sampled at the same offset.
  task automatic host_write(input logic [1:0] a, input logic [31:0] d);
    csr_wr = 1'b1; csr_addr = a; csr_wdata = d;
    @(posedge clk); #1;
    csr_wr = 1'b0;
  endtask

  task automatic host_read(input logic [1:0] a, output logic [31:0] d, output logic v);
    csr_rd = 1'b1; csr_addr = a;
    @(posedge clk); #1;
    csr_rd = 1'b0;
    d = csr_rdata; v = csr_rvalid;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic v;
    checks++; if (csr_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b exp 0", csr_rvalid); end
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h exp 0", csr_rdata); end
    checks++; if (tc_req !== 16'h0) begin errors++; $display("FAIL rst_tc_req: got %h exp 0", tc_req); end
    checks++; if ({tc_wr, tc_addr, tc_wdata} !== 49'h0) begin errors++; $display("FAIL rst_tc_bus: got %b %h %h exp 0", tc_wr, tc_addr, tc_wdata); end
    host_read(W_CMD, d, v);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_status: got %h exp 0", d); end
  endtask

  task automatic test_csr_access();
    logic [31:0] d; logic v;
    host_write(W_ADDR, 32'h0000_1111);
    host_read(W_ADDR, d, v);
    checks++; if (v !== 1'b1) begin errors++; $display("FAIL acc_rvalid: got %b exp 1", v); end
    checks++; if (d !== 32'h0000_1111) begin errors++; $display("FAIL acc_addr: got %h exp 00001111", d); end
    checks++; if (csr_rvalid !== 1'b1) begin errors++; $display("FAIL acc_rvalid_hold: got %b exp 1", csr_rvalid); end
    #1; // still before the next edge
    cycles(1);
    checks++; if (csr_rvalid !== 1'b0) begin errors++; $display("FAIL acc_rvalid_drop: got %b exp 0", csr_rvalid); end
    // A write and a read in the same cycle: the read returns the old value.
    csr_wr = 1'b1; csr_rd = 1'b1; csr_addr = W_ADDR; csr_wdata = 32'h0000_2222;
    @(posedge clk); #1;
    csr_wr = 1'b0; csr_rd = 1'b0;
    checks++; if (csr_rdata !== 32'h0000_1111) begin errors++; $display("FAIL acc_same_cycle: got %h exp 00001111", csr_rdata); end
    host_read(W_ADDR, d, v);
    checks++; if (d !== 32'h0000_2222) begin errors++; $display("FAIL acc_after_wr: got %h exp 00002222", d); end
    host_write(W_WRD, 32'hCAFE_F00D);
    host_read(W_WRD, d, v);
    checks++; if (d !== 32'hCAFE_F00D) begin errors++; $display("FAIL acc_wrdata: got %h exp cafef00d", d); end
  endtask

  task automatic test_read_ch3();
    logic [31:0] d; logic v;
    host_write(W_ADDR, 32'h0003_0009);
    host_write(W_CMD, 32'h1);
    checks++; if (tc_req !== 16'h0008) begin errors++; $display("FAIL rd_req: got %h exp 0008", tc_req); end
    checks++; if (tc_wr !== 1'b0 || tc_addr !== 16'h0009) begin errors++; $display("FAIL rd_bus: got wr=%b addr=%h exp wr=0 addr=0009", tc_wr, tc_addr); end
    cycles(1);
    checks++; if (tc_req !== 16'h0) begin errors++; $display("FAIL rd_req_pulse: got %h exp 0", tc_req); end
    host_read(W_CMD, d, v);
    checks++; if (d !== 32'h5) begin errors++; $display("FAIL rd_busy: got %h exp 5", d); end
    tc_rdata[3*32 +: 32] = 32'h0000_1234;
    cycles(3);
    tc_ack = 16'h0008;
    cycles(1);
    tc_ack = 16'h0;
    host_read(W_CMD, d, v);
    checks++; if (d !== 32'h9) begin errors++; $display("FAIL rd_done: got %h exp 9", d); end
    host_read(W_RDD, d, v);
    checks++; if (d !== 32'h0000_1234) begin errors++; $display("FAIL rd_data: got %h exp 00001234", d); end
  endtask

  task automatic test_broadcast();
    logic [31:0] d; logic v;
    host_write(W_ADDR, 32'h8000_0200);
    host_write(W_WRD, 32'h1);
    host_write(W_CMD, 32'h2);
    checks++; if (tc_req !== 16'hFFFF) begin errors++; $display("FAIL bc_req: got %h exp ffff", tc_req); end
    checks++; if (tc_wr !== 1'b1 || tc_addr !== 16'h0200 || tc_wdata !== 32'h1) begin errors++; $display("FAIL bc_bus: got wr=%b addr=%h data=%h exp 1 0200 1", tc_wr, tc_addr, tc_wdata); end
    cycles(1);
    checks++; if (tc_req !== 16'h0) begin errors++; $display("FAIL bc_req_pulse: got %h exp 0", tc_req); end
    // Two channels ack per cycle. Channel 0 acks again as a duplicate. Each
    // read captures the status from before that cycle's acks.
    for (int j = 0; j < 8; j++) begin
      tc_ack = (16'h3 << (2 * j)) | ((j == 1) ? 16'h1 : 16'h0);
      csr_rd = 1'b1; csr_addr = W_CMD;
      @(posedge clk); #1;
      tc_ack = 16'h0; csr_rd = 1'b0;
      checks++; if (csr_rdata !== 32'h6) begin errors++; $display("FAIL bc_busy_%0d: got %h exp 6", j, csr_rdata); end
    end
    host_read(W_CMD, d, v);
    checks++; if (d !== 32'hA) begin errors++; $display("FAIL bc_done: got %h exp a", d); end
  endtask

  task automatic test_timeout();
    logic [31:0] d; logic v;
    host_write(W_ADDR, 32'h0005_0000);
    host_write(W_CMD, 32'h1);
    cycles(TMO);
    host_read(W_CMD, d, v);
    checks++; if (d !== 32'h5) begin errors++; $display("FAIL to_busy_last: got %h exp 5", d); end
    host_read(W_CMD, d, v);
    checks++; if (d !== 32'h19) begin errors++; $display("FAIL to_status: got %h exp 19", d); end
    host_read(W_RDD, d, v);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL to_rddata: got %h exp ffffffff", d); end
    // An ack on the terminal-count cycle completes the command normally.
    host_write(W_CMD, 32'h1);
    cycles(TMO);
    tc_rdata[5*32 +: 32] = 32'h5555_AAAA;
    tc_ack = 16'h0020; csr_rd = 1'b1; csr_addr = W_CMD;
    @(posedge clk); #1;
    tc_ack = 16'h0; csr_rd = 1'b0;
    checks++; if (csr_rdata !== 32'h5) begin errors++; $display("FAIL to_ack_busy: got %h exp 5", csr_rdata); end
    host_read(W_CMD, d, v);
    checks++; if (d !== 32'h9) begin errors++; $display("FAIL to_ack_status: got %h exp 9", d); end
    host_read(W_RDD, d, v);
    checks++; if (d !== 32'h5555_AAAA) begin errors++; $display("FAIL to_ack_data: got %h exp 5555aaaa", d); end
  endtask

  task automatic test_illegal();
    logic [31:0] d; logic v;
    host_write(W_ADDR, 32'h0005_0000);
    host_write(W_CMD, 32'h3);
    checks++; if (tc_req !== 16'h0) begin errors++; $display("FAIL ill3_req: got %h exp 0", tc_req); end
    host_read(W_CMD, d, v);
    checks++; if (d !== 32'h2B) begin errors++; $display("FAIL ill3_status: got %h exp 2b", d); end
    host_write(W_ADDR, 32'h8000_0000);
    host_write(W_CMD, 32'h1);
    checks++; if (tc_req !== 16'h0) begin errors++; $display("FAIL illbc_req: got %h exp 0", tc_req); end
    host_read(W_CMD, d, v);
    checks++; if (d !== 32'h29) begin errors++; $display("FAIL illbc_status: got %h exp 29", d); end
    // Instance b: channel 7 is out of range, channel 3 is the last legal one.
    b_csr_wr = 1'b1; b_csr_addr = W_ADDR; b_csr_wdata = 32'h0007_0000;
    cycles(1);
    b_csr_addr = W_CMD; b_csr_wdata = 32'h1;
    cycles(1);
    b_csr_wr = 1'b0;
    checks++; if (b_tc_req !== 4'h0) begin errors++; $display("FAIL illch_req: got %h exp 0", b_tc_req); end
    b_csr_rd = 1'b1; b_csr_addr = W_CMD;
    cycles(1);
    b_csr_rd = 1'b0;
    checks++; if (b_csr_rdata !== 32'h29) begin errors++; $display("FAIL illch_status: got %h exp 29", b_csr_rdata); end
    b_csr_wr = 1'b1; b_csr_addr = W_ADDR; b_csr_wdata = 32'h0003_0000;
    cycles(1);
    b_csr_addr = W_CMD; b_csr_wdata = 32'h1;
    cycles(1);
    b_csr_wr = 1'b0;
    checks++; if (b_tc_req !== 4'h8) begin errors++; $display("FAIL lastch_req: got %h exp 8", b_tc_req); end
    cycles(2);
    b_tc_ack = 4'h8;
    cycles(1);
    b_tc_ack = 4'h0;
    b_csr_rd = 1'b1; b_csr_addr = W_CMD;
    cycles(1);
    b_csr_rd = 1'b0;
    checks++; if (b_csr_rdata !== 32'h9) begin errors++; $display("FAIL lastch_status: got %h exp 9", b_csr_rdata); end
  endtask

  task automatic test_overrun();
    logic [31:0] d; logic v;
    tc_rdata[2*32 +: 32] = 32'h0000_BEEF;
    host_write(W_ADDR, 32'h0002_0004);
    host_write(W_CMD, 32'h1);
    checks++; if (tc_req !== 16'h0004) begin errors++; $display("FAIL ov_req: got %h exp 0004", tc_req); end
    host_write(W_CMD, 32'h2);
    host_write(W_ADDR, 32'h0006_0000);
    checks++; if (tc_addr !== 16'h0004 || tc_wr !== 1'b0) begin errors++; $display("FAIL ov_snapshot: got addr=%h wr=%b exp 0004 0", tc_addr, tc_wr); end
    tc_ack = 16'h0004;
    cycles(1);
    tc_ack = 16'h0;
    host_read(W_CMD, d, v);
    checks++; if (d !== 32'h49) begin errors++; $display("FAIL ov_status: got %h exp 49", d); end
    host_read(W_RDD, d, v);
    checks++; if (d !== 32'h0000_BEEF) begin errors++; $display("FAIL ov_data: got %h exp 0000beef", d); end
    host_write(W_CMD, 32'h40);
    host_read(W_CMD, d, v);
    checks++; if (d !== 32'h9) begin errors++; $display("FAIL ov_clear: got %h exp 9", d); end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] d; logic v;
    host_write(W_ADDR, 32'h0001_0000);
    host_write(W_CMD, 32'h1);
    cycles(2);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    tc_rdata[1*32 +: 32] = 32'h0000_7777;
    tc_ack = 16'h0002;
    cycles(1);
    tc_ack = 16'h0;
    checks++; if ({tc_req, tc_wr, tc_addr, tc_wdata} !== 65'h0) begin errors++; $display("FAIL mid_tc_bus: got %h %b %h %h exp 0", tc_req, tc_wr, tc_addr, tc_wdata); end
    host_read(W_CMD, d, v);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_status: got %h exp 0", d); end
    host_read(W_RDD, d, v);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_rddata: got %h exp 0", d); end
    host_read(W_ADDR, d, v);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_address: got %h exp 0", d); end
    // The engine accepts a fresh command straight away.
    host_write(W_ADDR, 32'h0001_0000);
    host_write(W_CMD, 32'h2);
    checks++; if (tc_req !== 16'h0002 || tc_wr !== 1'b1) begin errors++; $display("FAIL mid_reissue: got %h wr=%b exp 0002 1", tc_req, tc_wr); end
    cycles(2);
    tc_ack = 16'h0002;
    cycles(1);
    tc_ack = 16'h0;
    host_read(W_CMD, d, v);
    checks++; if (d !== 32'hA) begin errors++; $display("FAIL mid_done: got %h exp a", d); end
  endtask

  initial begin
    rst = 1'b1;
    csr_wr = 1'b0; csr_rd = 1'b0; csr_addr = 2'd0; csr_wdata = 32'h0; tc_ack = 16'h0;
    b_csr_wr = 1'b0; b_csr_rd = 1'b0; b_csr_addr = 2'd0; b_csr_wdata = 32'h0; b_tc_ack = 4'h0;
    for (int i = 0; i < 16; i++) tc_rdata[i*32 +: 32] = 32'hA000_0000 | 32'(i);
    for (int i = 0; i < 4; i++) b_tc_rdata[i*32 +: 32] = 32'hB000_0000 | 32'(i);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    test_reset();
    test_csr_access();
    test_read_ch3();
    test_broadcast();
    test_timeout();
    test_illegal();
    test_overrun();
    test_reset_mid_op();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
